mouse_packet_bus_if: RTL
========================

Name: mouse_packet_bus_if

Overview:
- Sits between the PS/2 byte receiver (mouse transceiver front end) and the microprocessor bus.
- Assembles the standard 3-byte PS/2 mouse packets from the received byte stream and maintains a clamped cursor position in screen coordinates.
- Exposes status, X, Y and packet count as bus-mapped registers, and raises a bus interrupt on each completed packet.
- Its X/Y outputs also feed the VGA cursor overlay and the seven-segment/LED display logic.

Parameters:
- BASE_ADDR, 8'hA0, bus base address; registers occupy BASE_ADDR..BASE_ADDR+3.
- MAX_X, 159, maximum cursor X (inclusive).
- MAX_Y, 119, maximum cursor Y (inclusive).
- INIT_X, 80, X position after reset.
- INIT_Y, 60, Y position after reset.
- TIMEOUT, 200000, CLK cycles allowed between bytes of one packet (2 ms at 100 MHz).

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-high reset.
- BYTE_IN  in  8  byte from the PS/2 receiver.
- BYTE_VALID  in  1  one-cycle strobe; BYTE_IN is valid this cycle.
- BYTE_ERROR  in  1  one-cycle strobe; parity/framing error on the current byte.
- BUS_ADDR  in  8  processor bus address.
- BUS_DATA  inout  8  shared tri-state data bus.
- BUS_WE  in  1  bus write enable.
- BUS_INTERRUPT_RAISE  out  1  interrupt request to the processor.
- BUS_INTERRUPT_ACK  in  1  interrupt acknowledge from the processor.
- MOUSE_X  out  8  current cursor X.
- MOUSE_Y  out  7  current cursor Y.
- MOUSE_STATUS  out  8  byte 0 of the last completed packet.

Behaviour:
- Reset, asynchronous:
  - State = WAIT_B0; MOUSE_X = INIT_X; MOUSE_Y = INIT_Y; MOUSE_STATUS = 0.
  - Packet count = 0; BUS_INTERRUPT_RAISE = 0; BUS_DATA = Z; timeout counter = 0.
  - Reset in mid-packet discards all partial bytes.
- FSM states: WAIT_B0, WAIT_B1, WAIT_B2, UPDATE.
  - WAIT_B0: on BYTE_VALID with BYTE_IN[3]=1, latch status and go to WAIT_B1. If bit3=0, discard the byte and stay (resync).
  - WAIT_B1: on BYTE_VALID, latch dx and go to WAIT_B2.
  - WAIT_B2: on BYTE_VALID, latch dy and go to UPDATE.
  - UPDATE: lasts one cycle; commits the outputs, then returns to WAIT_B0.
- Timeout counter: clears on every accepted byte and counts while in WAIT_B1/WAIT_B2. On reaching TIMEOUT, return to WAIT_B0 and drop the partial packet.
- BYTE_ERROR in any state: return to WAIT_B0 and drop the partial packet. If BYTE_ERROR and BYTE_VALID are asserted together, the error wins.
- Arithmetic, in UPDATE:
  - dx = 9-bit signed {status[4], dx_byte}; dy = 9-bit signed {status[5], dy_byte}.
  - If status[6] (X overflow) = 1, dx = 0. If status[7] (Y overflow) = 1, dy = 0.
  - X_new = X + dx, clamped to [0, MAX_X].
  - Y_new = Y − dy, clamped to [0, MAX_Y]; PS/2 up is screen up.
  - Compute with 10-bit signed intermediates so no wrap-around is possible.
- Commit timing: the cycle after UPDATE, MOUSE_X, MOUSE_Y and MOUSE_STATUS hold the new values. The packet count increments modulo 256. BUS_INTERRUPT_RAISE is set.
- Interrupt:
  - BUS_INTERRUPT_RAISE stays high until a cycle with BUS_INTERRUPT_ACK=1, then clears on the next edge.
  - If UPDATE and ACK occur in the same cycle, RAISE stays 1; the new packet wins.
  - Packets complete regardless of the interrupt state; no queueing.
- Register map:
  - BASE+0: status, read-only.
  - BASE+1: X, read/write.
  - BASE+2: Y, read/write.
  - BASE+3: packet count, read-only.
- Bus read:
  - When BUS_WE=0 and BUS_ADDR is in range, the data is registered and BUS_DATA is driven for exactly the following cycle (1-cycle latency). Otherwise BUS_DATA = Z.
  - The drive enable is registered and must drop when the address leaves range.
- Bus write:
  - BUS_WE=1 to BASE+1 or BASE+2 loads X or Y. Values above MAX are clamped to MAX. Writes to BASE+0 and BASE+3 are ignored.
  - If a bus write and UPDATE target the same register in one cycle, the bus write wins.

Decomposition:
- Shared package holds:
  - register offsets (REG_STATUS=0, REG_X=1, REG_Y=2, REG_COUNT=3);
  - FSM state encoding;
  - status bit indices (XSIGN=4, YSIGN=5, XOVF=6, YOVF=7, SYNC=3).
- One natural sub-module: mouse_axis_clamp, the signed add, clamp and overflow-zero logic for a single axis. It is instantiated twice, once per axis; Y uses the negated delta.

Test Plan:
- Reset then packet 08,05,03 → X=85, Y=57, STATUS=08, count=1, RAISE=1; ACK one cycle → RAISE=0 next edge.
- Packet 18,F6,00 (dx=−10) from X=5 → X=0 (clamped low). Packet 08,FF,00 from X=150 → X=159 (clamped high).
- Byte 00 in WAIT_B0 (sync=0), then 08,01,01 → byte discarded, X=81, Y=59, count=1.
- Bytes 08,05, then no byte for TIMEOUT+1 cycles, then 08,01,00 → only the last packet applies: X=81.
- BYTE_ERROR pulsed after byte 1 → no update, count unchanged. Packet 48,10,00 (X overflow) → X unchanged, STATUS=48.
- Write BUS_ADDR=A1, data=C8 → X=159. Read A2 → BUS_DATA=Y one cycle later, Z otherwise. Write A3 → count unchanged.

Source files
------------

// File: rtl/mouse_packet_bus_if_pkg.sv
// Shared definitions for the PS/2 mouse packet bus interface.
package mouse_packet_bus_if_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DELTA_W = 10;

    // Register offsets from the bus base address
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_X      = 2'd1;
    localparam logic [1:0] REG_Y      = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    // Bit positions inside PS/2 status byte 0
    localparam int unsigned BIT_SYNC  = 3;
    localparam int unsigned BIT_XSIGN = 4;
    localparam int unsigned BIT_YSIGN = 5;
    localparam int unsigned BIT_XOVF  = 6;
    localparam int unsigned BIT_YOVF  = 7;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    // Saturate an unsigned byte to an inclusive maximum
    function automatic logic [BYTE_W-1:0] clamp_byte(input logic [BYTE_W-1:0] v,
                                                     input logic [BYTE_W-1:0] max);
        return (v > max) ? max : v;
    endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// One cursor axis: sign-extend the delta, zero it on overflow, add and clamp.
module mouse_axis_clamp
    import mouse_packet_bus_if_pkg::*;
#(
    parameter logic [7:0] MAX = 8'd159
) (
    input  logic [7:0] pos,
    input  logic [7:0] delta,
    input  logic       sign,
    input  logic       ovf,
    input  logic       negate,
    output logic [7:0] pos_new_c
);

    logic signed [DELTA_W-1:0] d;
    logic signed [DELTA_W-1:0] d_eff;
    logic signed [DELTA_W-1:0] sum;

    // 10-bit signed math covers [-256, 511], so nothing can wrap before the clamp
    always_comb begin
        d     = ovf ? '0 : signed'({sign, sign, delta});
        d_eff = negate ? -d : d;
        sum   = signed'({2'b00, pos}) + d_eff;
        if (sum < 0) begin
            pos_new_c = '0;
        end else if (sum > signed'({2'b00, MAX})) begin
            pos_new_c = MAX;
        end else begin
            pos_new_c = sum[7:0];
        end
    end

endmodule

// File: rtl/mouse_packet_bus_if.sv
// Assembles 3-byte PS/2 mouse packets, tracks a clamped cursor and exposes it on the bus.
module mouse_packet_bus_if
    import mouse_packet_bus_if_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR = 8'hA0,
    parameter logic [7:0]  MAX_X     = 8'd159,
    parameter logic [6:0]  MAX_Y     = 7'd119,
    parameter logic [7:0]  INIT_X    = 8'd80,
    parameter logic [6:0]  INIT_Y    = 7'd60,
    parameter int unsigned TIMEOUT   = 200000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BYTE_IN,
    input  logic       BYTE_VALID,
    input  logic       BYTE_ERROR,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK,
    output logic [7:0] MOUSE_X,
    output logic [6:0] MOUSE_Y,
    output logic [7:0] MOUSE_STATUS
);

    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state_q;
    state_t          state_d;
    logic            take_status_c;
    logic            take_dx_c;
    logic            take_dy_c;
    logic            update_c;
    logic            waiting_c;
    logic            timeout_c;
    logic [7:0]      status_b;
    logic [7:0]      dx_b;
    logic [7:0]      dy_b;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      packet_count;
    logic [7:0]      x_new_c;
    logic [7:0]      y_new_c;
    logic [7:0]      offset_c;
    logic            in_range_c;
    logic            wr_x_c;
    logic            wr_y_c;
    logic [7:0]      rd_mux_c;
    logic [7:0]      rd_data;
    logic            rd_en;

    // Inter-byte timeout qualification
    always_comb begin
        waiting_c = (state_q == WAIT_B1) || (state_q == WAIT_B2);
        timeout_c = waiting_c && (to_cnt == TO_W'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= WAIT_B0;
        else       state_q <= state_d;
    end

    // Next state and byte-capture strobes; an error beats a byte in the same cycle
    always_comb begin
        state_d       = state_q;
        take_status_c = 1'b0;
        take_dx_c     = 1'b0;
        take_dy_c     = 1'b0;
        update_c      = 1'b0;
        case (state_q)
            WAIT_B0: begin
                if (!BYTE_ERROR && BYTE_VALID && BYTE_IN[BIT_SYNC]) begin
                    take_status_c = 1'b1;
                    state_d       = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (BYTE_ERROR) begin
                    state_d = WAIT_B0;
                end else if (BYTE_VALID) begin
                    take_dx_c = 1'b1;
                    state_d   = WAIT_B2;
                end else if (timeout_c) begin
                    state_d = WAIT_B0;
                end
            end
            WAIT_B2: begin
                if (BYTE_ERROR) begin
                    state_d = WAIT_B0;
                end else if (BYTE_VALID) begin
                    take_dy_c = 1'b1;
                    state_d   = UPDATE;
                end else if (timeout_c) begin
                    state_d = WAIT_B0;
                end
            end
            UPDATE: begin
                update_c = 1'b1;
                state_d  = WAIT_B0;
            end
            default: state_d = WAIT_B0;
        endcase
    end

    // Packet byte holding registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            status_b <= '0;
            dx_b     <= '0;
            dy_b     <= '0;
        end else begin
            if (take_status_c) status_b <= BYTE_IN;
            if (take_dx_c)     dx_b     <= BYTE_IN;
            if (take_dy_c)     dy_b     <= BYTE_IN;
        end
    end

    // Idle-cycle counter while waiting for the second and third bytes
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt <= '0;
        end else if (waiting_c && !BYTE_VALID && !timeout_c) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    mouse_axis_clamp #(.MAX(MAX_X)) u_clamp_x (
        .pos       (MOUSE_X),
        .delta     (dx_b),
        .sign      (status_b[BIT_XSIGN]),
        .ovf       (status_b[BIT_XOVF]),
        .negate    (1'b0),
        .pos_new_c (x_new_c)
    );

    // PS/2 positive Y is up, screen Y grows downward
    mouse_axis_clamp #(.MAX({1'b0, MAX_Y})) u_clamp_y (
        .pos       ({1'b0, MOUSE_Y}),
        .delta     (dy_b),
        .sign      (status_b[BIT_YSIGN]),
        .ovf       (status_b[BIT_YOVF]),
        .negate    (1'b1),
        .pos_new_c (y_new_c)
    );

    // Bus address decode and read mux
    always_comb begin
        offset_c   = BUS_ADDR - BASE_ADDR;
        in_range_c = (offset_c < 8'd4);
        wr_x_c     = BUS_WE && in_range_c && (offset_c[1:0] == REG_X);
        wr_y_c     = BUS_WE && in_range_c && (offset_c[1:0] == REG_Y);
        case (offset_c[1:0])
            REG_STATUS: rd_mux_c = MOUSE_STATUS;
            REG_X:      rd_mux_c = MOUSE_X;
            REG_Y:      rd_mux_c = {1'b0, MOUSE_Y};
            REG_COUNT:  rd_mux_c = packet_count;
            default:    rd_mux_c = packet_count;
        endcase
    end

    // Cursor, status, count and interrupt; bus writes override a same-cycle update
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            MOUSE_X             <= INIT_X;
            MOUSE_Y             <= INIT_Y;
            MOUSE_STATUS        <= '0;
            packet_count        <= '0;
            BUS_INTERRUPT_RAISE <= 1'b0;
        end else begin
            if (wr_x_c)        MOUSE_X <= clamp_byte(BUS_DATA, MAX_X);
            else if (update_c) MOUSE_X <= x_new_c;
            if (wr_y_c)        MOUSE_Y <= 7'(clamp_byte(BUS_DATA, {1'b0, MAX_Y}));
            else if (update_c) MOUSE_Y <= y_new_c[6:0];
            if (update_c) begin
                MOUSE_STATUS <= status_b;
                packet_count <= packet_count + 8'd1;
            end
            if (update_c)               BUS_INTERRUPT_RAISE <= 1'b1;
            else if (BUS_INTERRUPT_ACK) BUS_INTERRUPT_RAISE <= 1'b0;
        end
    end

    // Registered read path: data appears on the bus the cycle after the request
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_en   <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_en   <= !BUS_WE && in_range_c;
            rd_data <= rd_mux_c;
        end
    end

    assign BUS_DATA = rd_en ? rd_data : 8'hzz;

endmodule
